// File: rtl/ysyx_25040111_wbu_pkg.sv
// Shared definitions for the writeback unit.
//   XLEN_DEF   : default data width
//   AW_DEF     : default register address width (RV32E, 16 registers)
//   NREG_DEF   : default register count (2**AW_DEF)
//   STARVE_DEF : default number of consecutive EXU losses before EXU is forced to win
//   gnt_e      : write-port grant encoding
package ysyx_25040111_wbu_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned NREG_DEF   = 1 << AW_DEF;
    localparam int unsigned STARVE_DEF = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EXU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_e;

endpackage

// File: rtl/ysyx_25040111_wbu_sb.sv
// Pending-load scoreboard.
//   clock, reset_n   : clock, asynchronous active-low reset
//   set_en, set_rd   : a load to set_rd is being issued (x0 ignored)
//   clr_en, clr_rd   : load data for clr_rd is accepted this cycle
//   chk_rs1, chk_rs2 : source registers to look up
//   hazard           : a non-zero source has a load still outstanding
module ysyx_25040111_wbu_sb
    import ysyx_25040111_wbu_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          hazard
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Clear is applied before set so a new load issued in the same cycle
    // that the previous one to the same register returns stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            pending_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        hazard = ((chk_rs1 != '0) && pending_q[chk_rs1]) ||
                 ((chk_rs2 != '0) && pending_q[chk_rs2]);
    end

endmodule

// File: rtl/ysyx_25040111_wbu.sv
// Writeback unit: sole driver of the register-file write port.
//   clock, reset_n           : clock, asynchronous active-low reset
//   exu_valid/ready/wen/rd/data : ALU result channel (wen=0 retires without writing)
//   lsu_valid/ready/rd/data  : load response channel
//   iss_load, iss_rd         : IDU issuing a load to iss_rd
//   chk_rs1, chk_rs2, hazard : RAW lookup against outstanding loads (combinational)
//   rf_wen/waddr/wdata       : registered regfile write port, one cycle after accept
//   retire_cnt               : number of accepted results, wrapping
module ysyx_25040111_wbu
    import ysyx_25040111_wbu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned STARVE = STARVE_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic            exu_wen,
    input  logic [AW-1:0]   exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_load,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            hazard,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     retire_cnt
);

    // The counter never exceeds STARVE: reaching it forces an EXU win.
    localparam int unsigned SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_W = SW'(STARVE);

    gnt_e            gnt;
    logic            acc;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            sel_wr;

    logic [SW-1:0]   starve_q, starve_d;
    logic            rf_wen_q, rf_wen_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;

    // Grant depends only on valids and the starve counter, never on data.
    always_comb begin
        gnt = GNT_NONE;
        if (reset_n) begin
            if (lsu_valid && !(exu_valid && (starve_q == STARVE_W))) begin
                gnt = GNT_LSU;
            end else if (exu_valid) begin
                gnt = GNT_EXU;
            end
        end
    end

    always_comb begin
        exu_ready = (gnt == GNT_EXU);
        lsu_ready = (gnt == GNT_LSU);
        acc       = (gnt != GNT_NONE);
        sel_rd    = (gnt == GNT_LSU) ? lsu_rd   : exu_rd;
        sel_data  = (gnt == GNT_LSU) ? lsu_data : exu_data;
        sel_wr    = (gnt == GNT_LSU) || exu_wen;
    end

    always_comb begin
        starve_d     = '0;
        rf_wen_d     = acc && sel_wr && (sel_rd != '0);
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_cnt_d = retire_cnt_q;
        if (exu_valid && (gnt != GNT_EXU)) begin
            starve_d = starve_q + 1'b1;
        end
        if (acc) begin
            rf_waddr_d   = sel_rd;
            rf_wdata_d   = sel_data;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q     <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            starve_q     <= starve_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        rf_wen     = rf_wen_q;
        rf_waddr   = rf_waddr_q;
        rf_wdata   = rf_wdata_q;
        retire_cnt = retire_cnt_q;
    end

    ysyx_25040111_wbu_sb #(
        .AW (AW)
    ) u_sb (
        .clock   (clock),
        .reset_n (reset_n),
        .set_en  (iss_load),
        .set_rd  (iss_rd),
        .clr_en  (gnt == GNT_LSU),
        .clr_rd  (lsu_rd),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .hazard  (hazard)
    );

endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
module tb_ysyx_25040111_wbu;

    localparam int STARVE = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        exu_valid, exu_ready, exu_wen;
    logic [3:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_load;
    logic [3:0]  iss_rd, chk_rs1, chk_rs2;
    logic        hazard, rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, retire_cnt;

    always #5 clock = ~clock;

    ysyx_25040111_wbu #(
        .XLEN   (32),
        .AW     (4),
        .STARVE (STARVE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_wen    (exu_wen),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .iss_load   (iss_load),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard     (hazard),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        logic        ev;
        logic        ew;
        logic [3:0]  erd;
        logic [31:0] ed;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ld;
        logic        il;
        logic [3:0]  ird;
        logic [3:0]  r1;
        logic [3:0]  r2;
    } in_t;

    typedef struct {
        in_t         i;
        logic        x_er;
        logic        x_lr;
        logic        x_hz;
        logic        x_wen;
        logic [3:0]  x_wa;
        logic [31:0] x_wd;
        logic [31:0] x_ret;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (from the behavioural rules).
    bit          m_pend[16];
    int          m_starve;
    logic [31:0] m_ret;

    function automatic in_t mk(input logic ev, input logic ew, input logic [3:0] erd,
                               input logic [31:0] ed, input logic lv, input logic [3:0] lrd,
                               input logic [31:0] ld, input logic il, input logic [3:0] ird,
                               input logic [3:0] r1, input logic [3:0] r2);
        in_t t;
        t.ev = ev; t.ew = ew; t.erd = erd; t.ed = ed;
        t.lv = lv; t.lrd = lrd; t.ld = ld;
        t.il = il; t.ird = ird; t.r1 = r1; t.r2 = r2;
        return t;
    endfunction

    task automatic add(input in_t i, input logic er, input logic lr, input logic hz,
                       input logic wen, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [31:0] ret);
        vec_t v;
        v.i = i; v.x_er = er; v.x_lr = lr; v.x_hz = hz;
        v.x_wen = wen; v.x_wa = wa; v.x_wd = wd; v.x_ret = ret;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t t);
        exu_valid = t.ev; exu_wen = t.ew; exu_rd = t.erd; exu_data = t.ed;
        lsu_valid = t.lv; lsu_rd = t.lrd; lsu_data = t.ld;
        iss_load = t.il; iss_rd = t.ird; chk_rs1 = t.r1; chk_rs2 = t.r2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        m_starve = 0;
        m_ret = 32'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t   cur;
        in_t   idle;
        bit    g_exu, g_lsu, e_hz, e_wen;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;

        idle = mk(0,0,0,0,0,0,0,0,0,0,0);

        // Reset state, with requests asserted while reset is held.
        reset_n = 1'b0;
        apply(mk(1,1,5,32'h1,1,3,32'h2,1,3,3,3));
        repeat (2) @(negedge clock);
        #1;
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_hazard",    hazard,    0);
        chk("rst_rf_wen",    rf_wen,    0);
        chk("rst_rf_waddr",  rf_waddr,  0);
        chk("rst_rf_wdata",  rf_wdata,  0);
        chk("rst_retire",    retire_cnt, 0);
        apply(idle);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors, applied one per cycle from a known reset state.
        add(mk(1,1,5,32'hDEADBEEF,0,0,0,0,0,0,0),          1,0,0, 1,5,32'hDEADBEEF, 1);
        add(mk(0,0,0,0,0,0,0,1,3,3,0),                      0,0,0, 0,0,0,            1);
        add(mk(0,0,0,0,0,0,0,0,0,3,0),                      0,0,1, 0,0,0,            1);
        add(mk(0,0,0,0,1,3,32'h11112222,0,0,3,0),           0,1,1, 1,3,32'h11112222, 2);
        add(mk(0,0,0,0,0,0,0,0,0,3,0),                      0,0,0, 0,0,0,            2);
        add(mk(1,1,1,32'hA0000001,1,2,32'hB0000001,0,0,0,0),0,1,0, 1,2,32'hB0000001, 3);
        add(mk(1,1,1,32'hA0000002,1,2,32'hB0000002,0,0,0,0),0,1,0, 1,2,32'hB0000002, 4);
        add(mk(1,1,1,32'hA0000003,1,2,32'hB0000003,0,0,0,0),1,0,0, 1,1,32'hA0000003, 5);
        add(mk(1,1,1,32'hA0000004,1,2,32'hB0000004,0,0,0,0),0,1,0, 1,2,32'hB0000004, 6);
        add(mk(1,1,0,32'h00000055,0,0,0,0,0,0,0),           1,0,0, 0,0,0,            7);
        add(mk(1,0,4,32'h00000066,0,0,0,0,0,0,0),           1,0,0, 0,0,0,            8);
        add(mk(0,0,0,0,0,0,0,1,0,0,0),                      0,0,0, 0,0,0,            8);
        add(mk(0,0,0,0,0,0,0,1,7,0,0),                      0,0,0, 0,0,0,            8);
        add(mk(0,0,0,0,1,7,32'h00000077,1,7,0,7),           0,1,1, 1,7,32'h00000077, 9);
        add(mk(0,0,0,0,0,0,0,0,0,0,7),                      0,0,1, 0,0,0,            9);
        add(mk(0,0,0,0,1,7,32'h00000088,0,0,0,7),           0,1,1, 1,7,32'h00000088, 10);
        add(mk(0,0,0,0,0,0,0,0,0,0,7),                      0,0,0, 0,0,0,            10);

        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clock);
            apply(tbl[n].i);
            #1;
            chk($sformatf("v%0d_exu_ready", n), exu_ready, tbl[n].x_er);
            chk($sformatf("v%0d_lsu_ready", n), lsu_ready, tbl[n].x_lr);
            chk($sformatf("v%0d_hazard", n),    hazard,    tbl[n].x_hz);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_rf_wen", n), rf_wen, tbl[n].x_wen);
            if (tbl[n].x_wen) begin
                chk($sformatf("v%0d_rf_waddr", n), rf_waddr, tbl[n].x_wa);
                chk($sformatf("v%0d_rf_wdata", n), rf_wdata, tbl[n].x_wd);
            end
            chk($sformatf("v%0d_retire", n), retire_cnt, tbl[n].x_ret);
        end

        // Randomized traffic against the reference model.
        @(negedge clock);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            cur = mk($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
                     4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 9) < 5, 4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            apply(cur);
            #1;
            g_lsu = cur.lv && !(cur.ev && m_starve == STARVE);
            g_exu = cur.ev && !g_lsu;
            e_hz  = (cur.r1 != 0 && m_pend[cur.r1]) || (cur.r2 != 0 && m_pend[cur.r2]);
            chk("rnd_exu_ready", exu_ready, g_exu);
            chk("rnd_lsu_ready", lsu_ready, g_lsu);
            chk("rnd_hazard",    hazard,    e_hz);

            e_wa  = g_lsu ? cur.lrd : cur.erd;
            e_wd  = g_lsu ? cur.ld  : cur.ed;
            e_wen = (g_lsu || (g_exu && cur.ew)) && e_wa != 0;
            if (cur.ev && !g_exu) m_starve++;
            else m_starve = 0;
            if (g_exu || g_lsu) m_ret = m_ret + 32'd1;
            if (g_lsu) m_pend[cur.lrd] = 1'b0;
            if (cur.il && cur.ird != 0) m_pend[cur.ird] = 1'b1;

            @(posedge clock);
            #1;
            chk("rnd_rf_wen", rf_wen, e_wen);
            if (e_wen) begin
                chk("rnd_rf_waddr", rf_waddr, e_wa);
                chk("rnd_rf_wdata", rf_wdata, e_wd);
            end
            chk("rnd_retire", retire_cnt, m_ret);
        end

        // Reset asserted while a transfer is being accepted.
        @(negedge clock);
        apply(idle);
        @(negedge clock);
        apply(mk(1,1,9,32'h0000CAFE,0,0,0,1,10,0,0));
        @(posedge clock);
        #1;
        chk("mid_pre_rf_wen", rf_wen, 1);
        @(negedge clock);
        apply(mk(1,1,9,32'h0000CAFE,1,10,32'h0000F00D,0,0,10,0));
        #1;
        chk("mid_lsu_ready", lsu_ready, 1);
        chk("mid_hazard",    hazard,    1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_exu_ready", exu_ready, 0);
        chk("mid_rst_lsu_ready", lsu_ready, 0);
        chk("mid_rst_hazard",    hazard,    0);
        @(posedge clock);
        #1;
        chk("mid_rst_rf_wen", rf_wen,     0);
        chk("mid_rst_retire", retire_cnt, 0);
        chk("mid_rst_ready_held", lsu_ready, 0);
        @(negedge clock);
        apply(mk(0,0,0,0,0,0,0,0,0,10,0));
        reset_n = 1'b1;
        #1;
        chk("mid_rel_hazard", hazard, 0);
        @(posedge clock);
        #1;
        chk("mid_rel_rf_wen", rf_wen,     0);
        chk("mid_rel_retire", retire_cnt, 0);
        @(negedge clock);
        apply(mk(1,1,2,32'h12345678,0,0,0,0,0,0,0));
        #1;
        chk("post_exu_ready", exu_ready, 1);
        @(posedge clock);
        #1;
        chk("post_rf_wen",   rf_wen,     1);
        chk("post_rf_wdata", rf_wdata,   32'h12345678);
        chk("post_retire",   retire_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
